// File: rtl/ber_checker_pkg.sv
// Shared definitions for the receive chain: datapath defaults common with the
// filter and control blocks, the checker state encoding and the counter ceiling.
package ber_checker_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OS_DEF   = 2;

    // Widest counter the checker supports; narrower counters slice this value.
    localparam int                    NB_CNT_MAX = 64;
    localparam logic [NB_CNT_MAX-1:0] CNT_SAT    = '1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

endpackage

// File: rtl/ber_checker_ref_delay_line.sv
// Reference bit history: a shift register of transmitted bits with a read mux,
// so the checker can line up a decided bit with the bit sent i_sel symbols ago.
module ref_delay_line #(
    parameter int NB_DELAY = 5
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_shift,
    input  logic                i_bit,
    input  logic [NB_DELAY-1:0] i_sel,
    output logic                o_bit
);

    localparam int LEN = 2 ** NB_DELAY;

    logic [LEN-1:0] line_reg;

    // Newest bit enters at position 0; position k holds the bit from k symbols ago.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            line_reg <= '0;
        end else if (i_enable && i_shift) begin
            line_reg <= {line_reg[LEN-2:0], i_bit};
        end
    end

    assign o_bit = line_reg[i_sel];

endmodule

// File: rtl/ber_checker.sv
// Bit error rate checker: slices one filter sample per symbol to a bit, searches
// the transmit-to-receive latency against the reference bits, then counts bits
// and bit errors with saturating counters.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_OS    = NB_OS_DEF,
    parameter int NB_DELAY = 5,
    parameter int NB_WIN   = 7,
    parameter int NB_CNT   = 64
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_ref,
    input  logic [NB_OS-1:0]    i_phase,
    input  logic                i_restart,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_locked,
    output logic [NB_DELAY-1:0] o_delay,
    output logic [NB_CNT-1:0]   o_err_count,
    output logic [NB_CNT-1:0]   o_bit_count
);

    localparam logic [NB_CNT-1:0]   CNT_MAX   = CNT_SAT[NB_CNT-1:0];
    localparam logic [NB_CNT-1:0]   CNT_ONE   = {{(NB_CNT-1){1'b0}}, 1'b1};
    localparam logic [NB_OS-1:0]    PHASE_ONE = {{(NB_OS-1){1'b0}}, 1'b1};
    localparam logic [NB_WIN-1:0]   WIN_LAST  = '1;
    localparam logic [NB_WIN-1:0]   WIN_ONE   = {{(NB_WIN-1){1'b0}}, 1'b1};
    localparam logic [NB_DELAY-1:0] CAND_LAST = '1;
    localparam logic [NB_DELAY-1:0] CAND_ONE  = {{(NB_DELAY-1){1'b0}}, 1'b1};

    // Phase tracking and slicing
    logic [NB_OS-1:0]    phase_cnt_reg;
    logic [NB_OS-1:0]    phase_now;
    logic                sample_hit;
    logic                data_nonneg;
    logic                bit_reg;
    logic                bit_valid_reg;

    // Latency search and counting
    state_t              state_reg;
    logic [NB_DELAY-1:0] cand_reg;
    logic [NB_DELAY-1:0] best_reg;
    logic [NB_WIN:0]     min_err_reg;
    logic [NB_WIN:0]     win_err_reg;
    logic [NB_WIN-1:0]   win_cnt_reg;
    logic                locked_reg;
    logic [NB_DELAY-1:0] delay_reg;
    logic [NB_CNT-1:0]   err_cnt_reg;
    logic [NB_CNT-1:0]   bit_cnt_reg;

    logic [NB_DELAY-1:0] ref_sel;
    logic                ref_bit;
    logic                mismatch;
    logic [NB_WIN:0]     win_err_total;

    // The symbol strobe clock is phase 0 regardless of where the counter was.
    assign phase_now   = i_valid ? '0 : phase_cnt_reg;
    assign sample_hit  = (phase_now == i_phase);
    assign data_nonneg = ($signed(i_data) >= $signed({NB_DATA{1'b0}}));

    // Free-running phase counter, realigned by every symbol strobe
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            phase_cnt_reg <= '0;
        end else if (i_enable) begin
            phase_cnt_reg <= phase_now + PHASE_ONE;
        end
    end

    // Hard decision on the selected phase; valid is dropped while frozen
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            bit_reg       <= 1'b0;
            bit_valid_reg <= 1'b0;
        end else if (!i_enable) begin
            bit_valid_reg <= 1'b0;
        end else begin
            bit_valid_reg <= sample_hit;
            if (sample_hit) begin
                bit_reg <= data_nonneg;
            end
        end
    end

    // While searching, compare against the candidate; once locked, the chosen delay.
    assign ref_sel = locked_reg ? delay_reg : cand_reg;

    ref_delay_line #(
        .NB_DELAY (NB_DELAY)
    ) u_ref_delay_line (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_shift  (i_valid),
        .i_bit    (i_ref),
        .i_sel    (ref_sel),
        .o_bit    (ref_bit)
    );

    assign mismatch      = bit_reg ^ ref_bit;
    assign win_err_total = win_err_reg + {{NB_WIN{1'b0}}, mismatch};

    // Latency search over all candidates, then saturating bit/error counting
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= SEARCH;
            cand_reg    <= '0;
            best_reg    <= '0;
            min_err_reg <= '1;
            win_err_reg <= '0;
            win_cnt_reg <= '0;
            locked_reg  <= 1'b0;
            delay_reg   <= '0;
            err_cnt_reg <= '0;
            bit_cnt_reg <= '0;
        end else if (i_enable) begin
            if (i_restart) begin
                // Restart outranks a coincident comparison, which is dropped.
                state_reg   <= SEARCH;
                cand_reg    <= '0;
                best_reg    <= '0;
                min_err_reg <= '1;
                win_err_reg <= '0;
                win_cnt_reg <= '0;
                locked_reg  <= 1'b0;
                delay_reg   <= '0;
                err_cnt_reg <= '0;
                bit_cnt_reg <= '0;
            end else if (bit_valid_reg) begin
                case (state_reg)
                    SEARCH: begin
                        if (win_cnt_reg == WIN_LAST) begin
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                            cand_reg    <= cand_reg + CAND_ONE;
                            // Strict compare keeps the lowest delay on ties.
                            if (win_err_total < min_err_reg) begin
                                min_err_reg <= win_err_total;
                                best_reg    <= cand_reg;
                            end
                            if (cand_reg == CAND_LAST) begin
                                state_reg  <= LOCK;
                                locked_reg <= 1'b1;
                                delay_reg  <= (win_err_total < min_err_reg) ? cand_reg : best_reg;
                            end
                        end else begin
                            win_cnt_reg <= win_cnt_reg + WIN_ONE;
                            win_err_reg <= win_err_total;
                        end
                    end
                    LOCK: begin
                        if (bit_cnt_reg != CNT_MAX) begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                        end
                        if (mismatch && (err_cnt_reg != CNT_MAX)) begin
                            err_cnt_reg <= err_cnt_reg + CNT_ONE;
                        end
                    end
                    default: state_reg <= SEARCH;
                endcase
            end
        end
    end

    assign o_bit       = bit_reg;
    assign o_bit_valid = bit_valid_reg;
    assign o_locked    = locked_reg;
    assign o_delay     = delay_reg;
    assign o_err_count = err_cnt_reg;
    assign o_bit_count = bit_cnt_reg;

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Receive-side stage directly downstream of the polyphase FIR filter (oversampling factor 4).
- Per symbol, picks one of the 4 filter output samples and slices it to a bit.
- Finds the transmit-to-receive latency by comparing decided bits against the transmitted reference bits, then counts bits and bit errors.

Parameters:
- NB_DATA, 8, width of the signed filter output sample.
- NB_OS, 2, log2 of samples per symbol (4 phases).
- NB_DELAY, 5, log2 of latency search range (0..31 symbols).
- NB_WIN, 7, log2 of symbols evaluated per candidate delay (128).
- NB_CNT, 64, width of the bit and error counters.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  1 = run; 0 = freeze all state.
- i_valid  in  1  symbol strobe from the control block; 1 clock every 2^NB_OS clocks.
- i_data  in  NB_DATA  signed filter output, one sample per clock.
- i_ref  in  1  transmitted bit; same bit that feeds the filter; sampled on i_valid.
- i_phase  in  NB_OS  sampling phase select.
- i_restart  in  1  one-clock pulse; clears counters and restarts the latency search.
- o_bit  out  1  decided bit.
- o_bit_valid  out  1  one-clock pulse qualifying o_bit.
- o_locked  out  1  latency search done.
- o_delay  out  NB_DELAY  selected latency in symbols.
- o_err_count  out  NB_CNT  errors counted since lock.
- o_bit_count  out  NB_CNT  bits compared since lock.

Behaviour:
- Reset: every register and output is 0, and the state machine is in SEARCH with candidate d=0 and min_err all ones.
- Enable: all updates require i_enable=1. With i_enable=0, every register holds, and o_bit_valid is forced to 0 on the following clock.
- Phase counter:
  - Set to 0 on any clock with i_valid=1; otherwise increments and wraps.
  - A decision is taken on the clock where phase counter == i_phase.
  - The i_valid clock is phase 0.
- Decision: bit = 1 when i_data >= 0 (i.e. i_data[NB_DATA-1]==0), else 0. A sample of exactly 0 decides 1. o_bit and o_bit_valid are registered, giving latency of 1 clock from the sampled clock.
- Reference delay line:
  - Shift register of 2^NB_DELAY bits.
  - On i_valid, i_ref is shifted into position 0.
  - The compared reference is position d while searching, and position o_delay once locked.
  - The comparison happens on the o_bit_valid clock, and the counter update lands 1 clock later.
- State SEARCH:
  - Per candidate d, count mismatches over 2^NB_WIN decided bits.
  - At window end, if err < min_err (strict), load min_err<=err and best<=d.
  - Then clear err and set d<=d+1.
  - After the window for d = 2^NB_DELAY-1, go to LOCK with o_delay<=best and o_locked<=1.
  - Ties resolve to the lowest d.
  - The delay line is not pre-filled, so the first window includes startup bits.
- State LOCK:
  - Each decided bit increments o_bit_count; each mismatch also increments o_err_count.
  - Both counters saturate at all ones and never wrap.
- i_restart:
  - Valid in any state; requires i_enable=1.
  - Go to SEARCH with d=0, min_err all ones, o_locked=0, o_delay=0, and both counters cleared.
  - If it coincides with a bit comparison, i_restart wins and that bit is discarded.
- Reset mid-operation: asynchronous return to the reset values above; no partial state is retained.
- i_phase may change at any time. It takes effect from the next phase-counter match, and it does not restart the search.

Decomposition:
- Shared package holds:
  - NB_DATA and NB_OS defaults, shared with the filter and control blocks.
  - State encodings SEARCH and LOCK.
  - Counter saturation value.
- One sub-module, ref_delay_line:
  - Parameter NB_DELAY.
  - Ports: clock, i_reset, i_enable, i_shift, i_bit, i_sel, o_bit.
  - Function: shift register plus read mux.

Test Plan:
- Reset: hold i_reset=0 for 100 ns with random i_data -> all outputs 0; o_bit_valid never pulses.
- Alignment:
  - Setup: NB_DELAY=3, NB_WIN=4, i_phase=2, PRBS9 i_ref. Drive i_data=+100 when the ref bit delayed 5 symbols is 1, else -100, at phase 2; drive 0 at other phases.
  - Expected: after 128 decided bits, o_locked=1 and o_delay=5.
  - Then, after 1000 further symbols: o_bit_count=1000, o_err_count=0.
- Error injection: as in Alignment, but invert the sample sign every 100th symbol after lock -> o_err_count=10 and o_bit_count=1000.
- Phase select:
  - Stimulus: correct samples at phase 2 only; phases 0, 1 and 3 carry inverted-sign samples.
  - i_phase=2 -> o_err_count=0.
  - i_phase=0 -> search selects any delay but error rate ≈50%.
  - Zero-valued sample -> o_bit=1.
- Enable/restart:
  - Drop i_enable for 40 clocks in LOCK -> counters and o_bit_valid frozen, and resume exactly afterwards.
  - Pulse i_restart -> o_locked=0, counters=0, and relock after 128 bits.
- Mid-search reset: assert i_reset during the third window -> immediate return to reset values; relock to o_delay=5 after release.
